// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// key_event_decoder : turns debounced key strobes/levels into short, long,
//                     double-click and auto-repeat one-cycle pulses.
// Revision          : 1.0
// ============================================================================
module key_event_decoder #(
  parameter int unsigned LONG_CNT   = 50_000_000,
  parameter int unsigned DOUBLE_CNT = 15_000_000,
  parameter int unsigned REPEAT_CNT = 10_000_000,
  parameter bit          REPEAT_EN  = 1'b1,
  parameter int unsigned CNT_W      = 26
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_flag,
  input  logic key_value,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_WAIT2     = 3'd2,
    S_PRESS2    = 3'd3,
    S_LONG_HOLD = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  logic             repeat_q, repeat_d;
  logic             busy_q, busy_d;
  logic             rep_clr;
  logic             counting;

  // Transition priorities: release beats timeout, second press beats window expiry.
  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    repeat_d = 1'b0;
    rep_clr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_flag) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (key_value) begin
          state_d = S_WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          state_d = S_LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      S_WAIT2: begin
        if (key_flag) begin
          state_d  = S_PRESS2;
          double_d = 1'b1;
        end else if (cnt_q == DOUBLE_LAST) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end
      S_PRESS2: begin
        if (key_value) state_d = S_IDLE;
      end
      S_LONG_HOLD: begin
        if (key_value) begin
          state_d = S_IDLE;
        end else if (REPEAT_EN && (cnt_q == REPEAT_LAST)) begin
          repeat_d = 1'b1;
          rep_clr  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // With repeat disabled the hold counter parks at its last value instead of wrapping.
  always_comb begin
    counting = (state_q == S_PRESS1) || (state_q == S_WAIT2) || (state_q == S_LONG_HOLD);
    if ((state_d != state_q) || rep_clr) begin
      cnt_d = '0;
    end else if ((state_q == S_LONG_HOLD) && !REPEAT_EN && (cnt_q == REPEAT_LAST)) begin
      cnt_d = cnt_q;
    end else if (counting) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign double_pulse = double_q;
  assign repeat_pulse = repeat_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// tb_key_event_decoder : directed plus random gestures against a timestamp
//                        based gesture model, two instances (repeat on/off).
// Revision             : 1.0
// ============================================================================
module tb_key_event_decoder;

  localparam int LONG_CNT   = 100;
  localparam int DOUBLE_CNT = 30;
  localparam int REPEAT_CNT = 20;

  localparam int UP    = 0;
  localparam int DOWN1 = 1;
  localparam int GAP   = 2;
  localparam int DOWN2 = 3;
  localparam int HELD  = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key_flag;
  logic key_value;
  logic a_short, a_long, a_double, a_repeat, a_busy;
  logic b_short, b_long, b_double, b_repeat, b_busy;

  int total = 0;
  int bad   = 0;

  int n_sh, n_lg, n_db, n_rp, n_lg_b, n_rp_b;

  int         ph [2];
  longint     since [2];
  longint     now = 0;
  logic [4:0] exp_o [2];

  always #5 sys_clk = ~sys_clk;

  key_event_decoder #(
    .LONG_CNT(LONG_CNT), .DOUBLE_CNT(DOUBLE_CNT), .REPEAT_CNT(REPEAT_CNT),
    .REPEAT_EN(1'b1), .CNT_W(8)
  ) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag), .key_value(key_value),
    .short_pulse(a_short), .long_pulse(a_long), .double_pulse(a_double),
    .repeat_pulse(a_repeat), .busy(a_busy)
  );

  key_event_decoder #(
    .LONG_CNT(LONG_CNT), .DOUBLE_CNT(DOUBLE_CNT), .REPEAT_CNT(REPEAT_CNT),
    .REPEAT_EN(1'b0), .CNT_W(8)
  ) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag), .key_value(key_value),
    .short_pulse(b_short), .long_pulse(b_long), .double_pulse(b_double),
    .repeat_pulse(b_repeat), .busy(b_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Gesture model: tracks how long the current phase has lasted by timestamps.
  task automatic model_step(input bit f, input bit v);
    now++;
    for (int k = 0; k < 2; k++) begin
      bit s, l, d, r, en;
      s = 1'b0; l = 1'b0; d = 1'b0; r = 1'b0;
      en = (k == 0);
      case (ph[k])
        UP: if (f) begin ph[k] = DOWN1; since[k] = now; end
        DOWN1: begin
          if (v) begin
            ph[k] = GAP; since[k] = now;
          end else if (now - since[k] == LONG_CNT) begin
            ph[k] = HELD; since[k] = now; l = 1'b1;
          end
        end
        GAP: begin
          if (f) begin
            ph[k] = DOWN2; d = 1'b1;
          end else if (now - since[k] == DOUBLE_CNT) begin
            ph[k] = UP; s = 1'b1;
          end
        end
        DOWN2: if (v) ph[k] = UP;
        HELD: begin
          if (v) begin
            ph[k] = UP;
          end else if (en && (now - since[k] == REPEAT_CNT)) begin
            r = 1'b1; since[k] = now;
          end
        end
        default: ph[k] = UP;
      endcase
      exp_o[k] = {s, l, d, r, (ph[k] != UP)};
    end
  endtask

  task automatic clear_counts();
    n_sh = 0; n_lg = 0; n_db = 0; n_rp = 0; n_lg_b = 0; n_rp_b = 0;
  endtask

  task automatic tick(input bit f, input bit v);
    key_flag  = f;
    key_value = v;
    @(posedge sys_clk);
    model_step(f, v);
    @(negedge sys_clk);
    check_val("outs_a", 32'({a_short, a_long, a_double, a_repeat, a_busy}), 32'(exp_o[0]));
    check_val("outs_b", 32'({b_short, b_long, b_double, b_repeat, b_busy}), 32'(exp_o[1]));
    n_sh   += int'(a_short);
    n_lg   += int'(a_long);
    n_db   += int'(a_double);
    n_rp   += int'(a_repeat);
    n_lg_b += int'(b_long);
    n_rp_b += int'(b_repeat);
  endtask

  task automatic press(input int hold);
    tick(1'b1, 1'b0);
    repeat (hold) tick(1'b0, 1'b0);
  endtask

  task automatic release_for(input int n);
    repeat (n) tick(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    check_val("rst_a", 32'({a_short, a_long, a_double, a_repeat, a_busy}), 32'd0);
    check_val("rst_b", 32'({b_short, b_long, b_double, b_repeat, b_busy}), 32'd0);
    repeat (3) @(negedge sys_clk);
    check_val("rst_hold_a", 32'({a_short, a_long, a_double, a_repeat, a_busy}), 32'd0);
    for (int k = 0; k < 2; k++) begin
      ph[k] = UP; since[k] = now; exp_o[k] = '0;
    end
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key_flag  = 1'b0;
    key_value = 1'b1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    do_reset();
    clear_counts();

    // short press
    press(40);
    release_for(40);
    check_val("short_cnt", n_sh, 1);
    check_val("short_other", n_lg + n_db + n_rp, 0);
    check_val("short_busy", 32'(a_busy), 32'd0);

    // long press with repeat
    clear_counts();
    press(165);
    release_for(5);
    check_val("long_cnt", n_lg, 1);
    check_val("repeat_cnt", n_rp, 3);
    check_val("long_other", n_sh + n_db, 0);
    check_val("long_busy", 32'(a_busy), 32'd0);

    // double click
    clear_counts();
    press(10);
    release_for(15);
    press(50);
    release_for(40);
    check_val("dbl_cnt", n_db, 1);
    check_val("dbl_other", n_sh + n_lg + n_rp, 0);

    // second press exactly on the last window cycle
    clear_counts();
    press(5);
    release_for(30);
    press(5);
    release_for(40);
    check_val("edge_dbl", n_db, 1);
    check_val("edge_short", n_sh, 0);

    // release exactly on the long-timeout cycle
    clear_counts();
    press(99);
    release_for(40);
    check_val("edge_long", n_lg, 0);
    check_val("edge_short2", n_sh, 1);

    // reset mid-hold, key stays pressed afterwards
    clear_counts();
    press(60);
    key_flag = 1'b0;
    key_value = 1'b0;
    do_reset();
    repeat (150) tick(1'b0, 1'b0);
    check_val("rst_no_long", n_lg + n_lg_b, 0);
    check_val("rst_busy", 32'(a_busy), 32'd0);
    release_for(5);

    // repeat disabled instance over a 200-cycle hold
    clear_counts();
    press(200);
    release_for(5);
    check_val("norep_long", n_lg_b, 1);
    check_val("norep_repeat", n_rp_b, 0);
    check_val("rep_on_repeat", n_rp, 5);

    // random gestures, with occasional stray strobes while the key is down
    for (int g = 0; g < 40; g++) begin
      int hold;
      int gap;
      hold = $urandom_range(1, 180);
      gap  = $urandom_range(1, 60);
      tick(1'b1, 1'b0);
      for (int i = 1; i < hold; i++) tick(($urandom_range(0, 63) == 0), 1'b0);
      repeat (gap) tick(1'b0, 1'b1);
    end
    release_for(40);
    check_val("final_busy", 32'({a_busy, b_busy}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
